// File: rtl/collision_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : collision_scanner_if
//  Purpose  : Event channel from the collision scanner to the entity
//             managers. One event is transferred when event_valid and
//             event_ready are both high on a rising clock edge.
//  Ports    : event_valid    - event pending (scanner -> consumer)
//             event_ready    - consumer accepts event (consumer -> scanner)
//             event_type     - 0=SHIP_HIT, 1=SHOT_ASTEROID, 2=SHOT_OOB
//             event_ast_idx  - asteroid slot index (0 if unused)
//             event_shot_idx - shot slot index (0 if unused)
//  Revision : 1.0 - initial release
// ============================================================================
interface collision_scanner_if #(
   parameter int AW = 2,
   parameter int SW = 2
);
   logic          event_valid;
   logic          event_ready;
   logic [1:0]    event_type;
   logic [AW-1:0] event_ast_idx;
   logic [SW-1:0] event_shot_idx;

   modport master (
      output event_valid,
      output event_type,
      output event_ast_idx,
      output event_shot_idx,
      input  event_ready
   );

   modport slave (
      input  event_valid,
      input  event_type,
      input  event_ast_idx,
      input  event_shot_idx,
      output event_ready
   );
endinterface
`default_nettype wire

// File: rtl/collision_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : collision_scanner
//  Purpose  : Sequential per-frame collision engine. On start it snapshots
//             the ship, asteroid and shot entities, then performs one check
//             per cycle: ship-vs-asteroid, asteroid-vs-shot (asteroid outer,
//             shot inner) and shot-vs-screen. Each hit is emitted as one
//             event on a valid/ready channel and the scan waits for it.
//  Ports    : clk        - clock
//             reset      - synchronous active-high reset
//             start      - one-cycle scan request, ignored while busy
//             ship       - ship entity word
//             asteroids  - packed asteroid entities, slot 0 in the LSBs
//             shots      - packed shot entities, slot 0 in the LSBs
//             busy       - scan in progress (including event stalls)
//             done       - one-cycle pulse at scan end
//             ev         - event channel (master side)
//  Revision : 1.0 - initial release
// ============================================================================
module collision_scanner #(
   parameter int MAX_ASTEROIDS = 3,
   parameter int MAX_SHOTS     = 3,
   parameter int ENTITY_SIZE   = 34,
   parameter int X_LSB         = 6,
   parameter int Y_LSB         = 16,
   parameter int SHIP_W        = 22,
   parameter int SHIP_H        = 22,
   parameter int AST_W         = 22,
   parameter int AST_H         = 22,
   parameter int SHOT_W        = 2,
   parameter int SHOT_H        = 2,
   parameter int SCREEN_W      = 320,
   parameter int SCREEN_H      = 240
) (
   input  wire logic                                 clk,
   input  wire logic                                 reset,
   input  wire logic                                 start,
   input  wire logic [ENTITY_SIZE-1:0]               ship,
   input  wire logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
   input  wire logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots,
   output logic                                      busy,
   output logic                                      done,
   collision_scanner_if.master                       ev
);

   localparam int AW = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1;
   localparam int SW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SHIP_CHK = 3'd1;
   localparam logic [2:0] S_PAIR_CHK = 3'd2;
   localparam logic [2:0] S_OOB_CHK  = 3'd3;
   localparam logic [2:0] S_EMIT     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [1:0] c_EV_SHIP_HIT      = 2'd0;
   localparam logic [1:0] c_EV_SHOT_ASTEROID = 2'd1;
   localparam logic [1:0] c_EV_SHOT_OOB      = 2'd2;

   localparam logic [10:0] c_SHIP_W   = 11'(SHIP_W);
   localparam logic [10:0] c_SHIP_H   = 11'(SHIP_H);
   localparam logic [10:0] c_AST_W    = 11'(AST_W);
   localparam logic [10:0] c_AST_H    = 11'(AST_H);
   localparam logic [10:0] c_SHOT_W   = 11'(SHOT_W);
   localparam logic [10:0] c_SHOT_H   = 11'(SHOT_H);
   localparam logic [10:0] c_SCREEN_W = 11'(SCREEN_W);
   localparam logic [10:0] c_SCREEN_H = 11'(SCREEN_H);

   localparam logic [AW-1:0] c_A_LAST = AW'(MAX_ASTEROIDS - 1);
   localparam logic [SW-1:0] c_S_LAST = SW'(MAX_SHOTS - 1);

   // AABB overlap; all sums widened to 11 bits so nothing wraps.
   function automatic logic f_overlap(
      input logic [9:0]  ax, ay,
      input logic [10:0] aw, ah,
      input logic [9:0]  bx, by,
      input logic [10:0] bw, bh
   );
      return ({1'b0, ax} < ({1'b0, bx} + bw)) &&
             ({1'b0, bx} < ({1'b0, ax} + aw)) &&
             ({1'b0, ay} < ({1'b0, by} + bh)) &&
             ({1'b0, by} < ({1'b0, ay} + ah));
   endfunction

   // ---------------------------------------------------------------- fields
   logic                     w_ast_in_act [MAX_ASTEROIDS];
   logic [9:0]               w_ast_in_x   [MAX_ASTEROIDS];
   logic [9:0]               w_ast_in_y   [MAX_ASTEROIDS];
   logic                     w_shot_in_act[MAX_SHOTS];
   logic [9:0]               w_shot_in_x  [MAX_SHOTS];
   logic [9:0]               w_shot_in_y  [MAX_SHOTS];

   for (genvar gi = 0; gi < MAX_ASTEROIDS; gi++) begin : g_ast_fields
      assign w_ast_in_act[gi] = asteroids[gi*ENTITY_SIZE + ENTITY_SIZE - 1];
      assign w_ast_in_x[gi]   = asteroids[gi*ENTITY_SIZE + X_LSB +: 10];
      assign w_ast_in_y[gi]   = asteroids[gi*ENTITY_SIZE + Y_LSB +: 10];
   end

   for (genvar gi = 0; gi < MAX_SHOTS; gi++) begin : g_shot_fields
      assign w_shot_in_act[gi] = shots[gi*ENTITY_SIZE + ENTITY_SIZE - 1];
      assign w_shot_in_x[gi]   = shots[gi*ENTITY_SIZE + X_LSB +: 10];
      assign w_shot_in_y[gi]   = shots[gi*ENTITY_SIZE + Y_LSB +: 10];
   end

   // Entity words carry bits this block never looks at; fold them here so
   // they are visibly consumed.
   logic w_unused_bits;
   assign w_unused_bits = ^{ship, asteroids, shots};

   // ---------------------------------------------------------------- state
   logic [2:0]               r_state;
   logic [2:0]               w_next;
   logic [2:0]               r_ret_state;   // check state to resume after EMIT
   logic [AW-1:0]            r_a;
   logic [SW-1:0]            r_s;

   logic                     r_ship_act;
   logic [9:0]               r_ship_x;
   logic [9:0]               r_ship_y;
   logic [MAX_ASTEROIDS-1:0] r_ast_act;
   logic [9:0]               r_ast_x [MAX_ASTEROIDS];
   logic [9:0]               r_ast_y [MAX_ASTEROIDS];
   logic [MAX_SHOTS-1:0]     r_shot_act;
   logic [9:0]               r_shot_x[MAX_SHOTS];
   logic [9:0]               r_shot_y[MAX_SHOTS];

   logic                     r_ship_hit;
   logic [MAX_ASTEROIDS-1:0] r_ast_hit;
   logic [MAX_SHOTS-1:0]     r_shot_hit;

   logic [1:0]               r_ev_type;
   logic [AW-1:0]            r_ev_ast;
   logic [SW-1:0]            r_ev_shot;

   // ---------------------------------------------------------------- current pair
   logic                     w_cur_ast_act;
   logic [9:0]               w_cur_ast_x;
   logic [9:0]               w_cur_ast_y;
   logic                     w_cur_shot_act;
   logic [9:0]               w_cur_shot_x;
   logic [9:0]               w_cur_shot_y;

   assign w_cur_ast_act  = r_ast_act[r_a];
   assign w_cur_ast_x    = r_ast_x[r_a];
   assign w_cur_ast_y    = r_ast_y[r_a];
   assign w_cur_shot_act = r_shot_act[r_s];
   assign w_cur_shot_x   = r_shot_x[r_s];
   assign w_cur_shot_y   = r_shot_y[r_s];

   // ---------------------------------------------------------------- hit detect
   logic       w_hit;
   logic [1:0] w_hit_type;

   always_comb begin
      w_hit      = 1'b0;
      w_hit_type = c_EV_SHIP_HIT;
      case (r_state)
         S_SHIP_CHK: begin
            w_hit_type = c_EV_SHIP_HIT;
            w_hit      = r_ship_act && !r_ship_hit && w_cur_ast_act &&
                         f_overlap(r_ship_x, r_ship_y, c_SHIP_W, c_SHIP_H,
                                   w_cur_ast_x, w_cur_ast_y, c_AST_W, c_AST_H);
         end
         S_PAIR_CHK: begin
            w_hit_type = c_EV_SHOT_ASTEROID;
            w_hit      = w_cur_ast_act && !r_ast_hit[r_a] &&
                         w_cur_shot_act && !r_shot_hit[r_s] &&
                         f_overlap(w_cur_ast_x, w_cur_ast_y, c_AST_W, c_AST_H,
                                   w_cur_shot_x, w_cur_shot_y, c_SHOT_W, c_SHOT_H);
         end
         S_OOB_CHK: begin
            w_hit_type = c_EV_SHOT_OOB;
            w_hit      = w_cur_shot_act && !r_shot_hit[r_s] &&
                         (({1'b0, w_cur_shot_x} >= c_SCREEN_W) ||
                          ({1'b0, w_cur_shot_y} >= c_SCREEN_H));
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- index advance
   // The step after a check is the same whether it happens straight away
   // (no hit) or after the event is accepted, so it is computed from the
   // originating check state in both cases.
   logic [2:0]    w_ctx;
   logic [2:0]    w_adv_state;
   logic [AW-1:0] w_adv_a;
   logic [SW-1:0] w_adv_s;

   always_comb begin
      w_ctx       = (r_state == S_EMIT) ? r_ret_state : r_state;
      w_adv_state = w_ctx;
      w_adv_a     = r_a;
      w_adv_s     = r_s;
      case (w_ctx)
         S_SHIP_CHK: begin
            if (r_a == c_A_LAST) begin
               w_adv_state = S_PAIR_CHK;
               w_adv_a     = '0;
               w_adv_s     = '0;
            end else begin
               w_adv_a = r_a + 1'b1;
            end
         end
         S_PAIR_CHK: begin
            if (r_s == c_S_LAST) begin
               w_adv_s = '0;
               if (r_a == c_A_LAST) begin
                  w_adv_state = S_OOB_CHK;
                  w_adv_a     = '0;
               end else begin
                  w_adv_a = r_a + 1'b1;
               end
            end else begin
               w_adv_s = r_s + 1'b1;
            end
         end
         S_OOB_CHK: begin
            if (r_s == c_S_LAST) begin
               w_adv_state = S_DONE;
               w_adv_s     = '0;
            end else begin
               w_adv_s = r_s + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------- FSM: next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = S_SHIP_CHK;
         S_SHIP_CHK,
         S_PAIR_CHK,
         S_OOB_CHK:  w_next = w_hit ? S_EMIT : w_adv_state;
         S_EMIT:     if (ev.event_ready) w_next = w_adv_state;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM: outputs
   always_comb begin
      busy           = (r_state != S_IDLE);
      done           = (r_state == S_DONE);
      ev.event_valid = (r_state == S_EMIT);
   end

   assign ev.event_type     = r_ev_type;
   assign ev.event_ast_idx  = r_ev_ast;
   assign ev.event_shot_idx = r_ev_shot;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ret_state <= S_IDLE;
         r_a         <= '0;
         r_s         <= '0;
         r_ship_act  <= 1'b0;
         r_ship_x    <= '0;
         r_ship_y    <= '0;
         r_ast_act   <= '0;
         r_shot_act  <= '0;
         for (int i = 0; i < MAX_ASTEROIDS; i++) begin
            r_ast_x[i] <= '0;
            r_ast_y[i] <= '0;
         end
         for (int i = 0; i < MAX_SHOTS; i++) begin
            r_shot_x[i] <= '0;
            r_shot_y[i] <= '0;
         end
         r_ship_hit  <= 1'b0;
         r_ast_hit   <= '0;
         r_shot_hit  <= '0;
         r_ev_type   <= '0;
         r_ev_ast    <= '0;
         r_ev_shot   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_ship_act <= ship[ENTITY_SIZE-1];
                  r_ship_x   <= ship[X_LSB +: 10];
                  r_ship_y   <= ship[Y_LSB +: 10];
                  for (int i = 0; i < MAX_ASTEROIDS; i++) begin
                     r_ast_act[i] <= w_ast_in_act[i];
                     r_ast_x[i]   <= w_ast_in_x[i];
                     r_ast_y[i]   <= w_ast_in_y[i];
                  end
                  for (int i = 0; i < MAX_SHOTS; i++) begin
                     r_shot_act[i] <= w_shot_in_act[i];
                     r_shot_x[i]   <= w_shot_in_x[i];
                     r_shot_y[i]   <= w_shot_in_y[i];
                  end
                  r_ship_hit <= 1'b0;
                  r_ast_hit  <= '0;
                  r_shot_hit <= '0;
                  r_a        <= '0;
                  r_s        <= '0;
               end
            end
            S_SHIP_CHK,
            S_PAIR_CHK,
            S_OOB_CHK: begin
               if (w_hit) begin
                  // Indices stay put; they are advanced when the event is taken.
                  r_ret_state <= r_state;
                  r_ev_type   <= w_hit_type;
                  r_ev_ast    <= (r_state == S_OOB_CHK)  ? '0 : r_a;
                  r_ev_shot   <= (r_state == S_SHIP_CHK) ? '0 : r_s;
                  if (r_state == S_SHIP_CHK) begin
                     r_ship_hit <= 1'b1;
                  end
                  if (r_state == S_PAIR_CHK) begin
                     r_ast_hit[r_a]  <= 1'b1;
                     r_shot_hit[r_s] <= 1'b1;
                  end
               end else begin
                  r_a <= w_adv_a;
                  r_s <= w_adv_s;
               end
            end
            S_EMIT: begin
               if (ev.event_ready) begin
                  r_a <= w_adv_a;
                  r_s <= w_adv_s;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/collision_scanner.md
# collision_scanner

Parametrised, sequential collision engine for the asteroids game core. On each `start` pulse it snapshots the ship, asteroid and shot entity vectors. It then walks ship-vs-asteroid, asteroid-vs-shot and shot-vs-screen checks one per cycle. Each hit is emitted as an event over a valid/ready handshake to the entity managers, which perform the deletes and life decrement. It sits between the entity RAM readers and the game-state controller, and runs once per frame.

## Interface
- MAX_ASTEROIDS, 3, asteroid slots (≥1)
- MAX_SHOTS, 3, shot slots (≥1)
- ENTITY_SIZE, 34, bits per entity word; bit ENTITY_SIZE-1 = active flag
- X_LSB, 6, LSB of 10-bit x field
- Y_LSB, 16, LSB of 10-bit y field
- SHIP_W / SHIP_H, 22 / 22, ship box size (pixels)
- AST_W / AST_H, 22 / 22, asteroid box size
- SHOT_W / SHOT_H, 2 / 2, shot box size
- SCREEN_W / SCREEN_H, 320 / 240, playfield size
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin scan; ignored while busy
- ship  in  ENTITY_SIZE  ship entity
- asteroids  in  MAX_ASTEROIDS×ENTITY_SIZE  packed asteroid entities
- shots  in  MAX_SHOTS×ENTITY_SIZE  packed shot entities
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- event_valid  out  1  event pending
- event_ready  in  1  consumer accepts event
- event_type  out  2  0=SHIP_HIT, 1=SHOT_ASTEROID, 2=SHOT_OOB
- event_ast_idx  out  AW=max(1,$clog2(MAX_ASTEROIDS))  asteroid index (0 if unused)
- event_shot_idx  out  SW=max(1,$clog2(MAX_SHOTS))  shot index (0 if unused)

## Operation
- FSM states: IDLE, SHIP_CHK, PAIR_CHK, OOB_CHK, EMIT, DONE.
- IDLE + start: register all inputs into snapshot, clear per-scan hit masks, go SHIP_CHK with index 0. Inputs are ignored after the snapshot.
- SHIP_CHK (index a = 0..MAX_ASTEROIDS-1): check ship active, asteroid a active and overlapping. On a hit, emit SHIP_HIT with ast_idx=a. At most one SHIP_HIT per scan; remaining ship checks are skipped after the first hit. After the last a, go to PAIR_CHK with a=0, s=0.
- PAIR_CHK: s is the inner loop, a the outer loop. Skip the pair if either entity is inactive or already hit this scan. On overlap: emit SHOT_ASTEROID(a,s), then set ast_hit[a] and shot_hit[s].
- OOB_CHK (s = 0..MAX_SHOTS-1): a shot is out of bounds when it is active, not in shot_hit, and x ≥ SCREEN_W or y ≥ SCREEN_H. Out-of-bounds shots emit SHOT_OOB(s). Coordinates are unsigned; there is no negative check.
- Overlap (AABB) between box A and box B holds when Ax < Bx+Bw, Bx < Ax+Aw, Ay < By+Bh and By < Ay+Ah. All sums are computed at 11 bits, so there is no wrap.
- EMIT: event_valid=1 and the event fields are held stable. When valid&&ready, return to the originating check state at the next index.
- DONE: done=1 for one cycle, then IDLE.
- Reset: FSM→IDLE; busy, done, event_valid, type and indices are 0; hit masks are cleared. A pending event is dropped.

## Timing
- start sampled in cycle 0 → busy=1 from cycle 1; first check in cycle 1.
- One check per cycle. A hit found in cycle n gives event_valid=1 in cycle n+1. The next check runs in the cycle after acceptance.
- No-hit scan: MAX_ASTEROIDS + MAX_ASTEROIDS·MAX_SHOTS + MAX_SHOTS check cycles, then 1 DONE cycle. With defaults that is 15 check cycles, done in cycle 16, busy=0 in cycle 17.
- Each accepted event adds 1 cycle when ready is already high, plus 1 cycle per stall cycle.
- event_valid never deasserts without acceptance, except on reset.
- A start pulse coincident with done or while busy is ignored.
- busy stays high through EMIT stalls.

## Test plan
- Defaults, ship (x=100,y=100, active), all others inactive; start → no events, done in cycle 16, busy low in cycle 17.
- Asteroids 0 and 2 overlap ship (x=110,y=110); ready=1 → exactly one SHIP_HIT (ast_idx=0), done in cycle 17.
- Asteroid 1 at (50,50); shots 0 and 2 at (55,55); ready=1 → single SHOT_ASTEROID(a=1,s=0) only, because asteroid 1 is consumed. Shot 2 is not reported.
- Shot 1 at x=320,y=10, and shot 2 at x=10,y=240; a shot at x=319,y=239 is not flagged → SHOT_OOB(1), then SHOT_OOB(2).
- Edge overlap: asteroid at x=0, shot at x=22 (touching) → no event; shot at x=21 → SHOT_ASTEROID.
- Hold ready=0 for 5 cycles on a pending event → fields are stable and busy=1; assert reset mid-stall → next cycle all outputs are 0 and the FSM is in IDLE.
